// File: rtl/cube.sv
// cube: multi-cycle shift-add integer cuber, y = x^3, start/busy handshake.
// Optional CUBE_DONE_PULSE_EN adds a one-cycle done pulse on completion.
module cube #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   x,
    output logic           busy,
    output logic [3*N-1:0] y
`ifdef CUBE_DONE_PULSE_EN
    ,
    output logic           done
`endif
);
    localparam int W  = 3 * N;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, SQ, CB} state_t;

    state_t         state;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   xr;
    logic [2*N-1:0] sq;
    logic [W-1:0]   acc;
    logic [W-1:0]   mc;
    logic [W-1:0]   sum;
    logic [CW-1:0]  cnt;
    logic           last;

    // The SQ pass multiplies by x, the CB pass by the stored square.
    always_comb begin
        mc   = (state == CB) ? W'(sq) : W'(mcand);
        sum  = acc + (mplier[0] ? (mc << cnt) : '0);
        last = cnt == CW'(N - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            xr     <= '0;
            sq     <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            y      <= '0;
`ifdef CUBE_DONE_PULSE_EN
            done   <= 1'b0;
`endif
        end else begin
`ifdef CUBE_DONE_PULSE_EN
            done <= 1'b0;
`endif
            case (state)
                IDLE: if (start) begin
                    mcand  <= x;
                    mplier <= x;
                    xr     <= x;
                    acc    <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= SQ;
                end
                SQ: begin
                    acc    <= last ? '0 : sum;
                    cnt    <= last ? '0 : cnt + 1'b1;
                    mplier <= last ? xr : mplier >> 1;
                    if (last) begin
                        sq    <= sum[2*N-1:0];
                        state <= CB;
                    end
                end
                CB: begin
                    acc    <= sum;
                    cnt    <= cnt + 1'b1;
                    mplier <= mplier >> 1;
                    if (last) begin
                        y     <= sum;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef CUBE_DONE_PULSE_EN
                        done  <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cube.sv
// tb_cube: table-driven, directed and randomized checks of the cube unit
// against an arithmetic x*x*x reference.
module tb_cube;
    localparam int N = 4;
    localparam int W = 3 * N;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] x = '0;
    logic         busy;
    logic [W-1:0] y;
`ifdef CUBE_DONE_PULSE_EN
    logic         done;
`endif

    int checks = 0;
    int errors = 0;

    cube #(.N(N)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .x    (x),
        .busy (busy),
        .y    (y)
`ifdef CUBE_DONE_PULSE_EN
        ,
        .done (done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] xin;
        logic [W-1:0] yexp;
    } vec_t;

    vec_t vecs[6];

    function automatic longint model(input longint v);
        return v * v * v;
    endfunction

    function automatic longint cbrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Pulses start with operand xv, optionally scrambles x during busy,
    // returns the result and the number of busy cycles observed.
    task automatic run(input logic [N-1:0] xv, input bit scramble,
                       output longint yv, output int cyc);
        @(negedge clk);
        x = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            if (scramble) x = N'($urandom);
            cyc++;
            @(negedge clk);
        end
        yv = longint'(y);
`ifdef CUBE_DONE_PULSE_EN
        check("done_on_fall", longint'(done), 1);
        @(negedge clk);
        check("done_one_cycle", longint'(done), 0);
`endif
    endtask

    initial begin
        longint yv, y5, y6;
        int cyc, gap;
        vecs[0] = '{4'd2, 12'd8};
        vecs[1] = '{4'd0, 12'd0};
        vecs[2] = '{4'd1, 12'd1};
        vecs[3] = '{4'd3, 12'd27};
        vecs[4] = '{4'd5, 12'd125};
        vecs[5] = '{4'd15, 12'd3375};

        repeat (2) @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_y", longint'(y), 0);
`ifdef CUBE_DONE_PULSE_EN
        check("reset_done", longint'(done), 0);
`endif
        reset = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i].xin, 1'b0, yv, cyc);
            check($sformatf("vec_y[%0d]", i), yv, longint'(vecs[i].yexp));
            check($sformatf("vec_cycles[%0d]", i), cyc, 2 * N);
        end

        // start and x changes while busy are ignored
        @(negedge clk);
        x = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == 3) begin
                x = 4'd7;
                start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
        end
        check("ignored_start_y", longint'(y), 27);
        check("ignored_start_cycles", cyc, 2 * N);
`ifdef CUBE_DONE_PULSE_EN
        check("ignored_start_done", longint'(done), 1);
`endif
        @(negedge clk);
        check("no_second_run", longint'(busy), 0);
`ifdef CUBE_DONE_PULSE_EN
        check("no_spurious_done", longint'(done), 0);
`endif

        // reset mid-operation discards the run
        x = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", longint'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_busy", longint'(busy), 0);
        check("midrun_reset_y", longint'(y), 0);
        // reset wins over a simultaneous start
        start = 1'b1;
        @(negedge clk);
        check("reset_vs_start_busy", longint'(busy), 0);
`ifdef CUBE_DONE_PULSE_EN
        check("reset_vs_start_done", longint'(done), 0);
`endif
        start = 1'b0;
        reset = 1'b0;
        run(4'd4, 1'b0, yv, cyc);
        check("after_reset_y", yv, 64);

        // start held high: back-to-back runs with one idle cycle between
        @(negedge clk);
        x = 4'd2;
        start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("held_cycles", cyc, 2 * N);
        check("held_y", longint'(y), 8);
        gap = 0;
        while (!busy && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        check("held_gap", gap, 1);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("held_second_y", longint'(y), 8);

        // round trip through an integer cube root
        for (int v = 0; v <= 6; v++) begin
            run(N'(v), 1'b0, yv, cyc);
            check($sformatf("roundtrip[%0d]", v), cbrt(yv & 255), v);
            if (v == 5) y5 = yv;
            if (v == 6) y6 = yv;
        end
        check("bracket_215", longint'(y5 <= 215 && 215 < y6), 1);

        // randomized operands, x scrambled during busy
        repeat (30) begin
            logic [N-1:0] xv;
            xv = N'($urandom_range(0, (1 << N) - 1));
            run(xv, 1'b1, yv, cyc);
            check($sformatf("rand_y[x=%0d]", xv), yv, model(longint'(xv)));
            check("rand_cycles", cyc, 2 * N);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
